// File: rtl/lsu_mem_adapter.sv
// Load/store adapter in front of a 32-bit word memory: word-aligned accesses,
// read-modify-write for sub-word stores, alignment/range checks, load extension.
module lsu_mem_adapter #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  localparam logic [31:0] MaxBase = 32'(MEM_BYTES - 4);

  state_e      state_q, state_d;
  logic        wr_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdbuf_q;
  logic        accept, req_bad;
  logic [31:0] req_base, base_q, merged, load_ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Base by masking only, so no carry can wrap past bit 31.
  assign req_base = {req_addr[31:2], 2'b00};
  assign base_q   = {addr_q[31:2], 2'b00};

  assign req_bad = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'b00) ||
                   (req_base > MaxBase);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdbuf_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= req_wr;
        uns_q   <= req_unsigned;
        err_q   <= req_bad;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == StRd) rdbuf_q <= mem_rdata;
    end
  end

  always_comb begin
    merged = rdbuf_q;
    case (size_q)
      2'd0:    merged[8*addr_q[1:0] +: 8] = wdata_q[7:0];
      2'd1:    merged[16*addr_q[1] +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign byte_v = rdbuf_q[8*addr_q[1:0] +: 8];
  assign half_v = rdbuf_q[16*addr_q[1] +: 16];

  always_comb begin
    case (size_q)
      2'd0:    load_ext = {{24{byte_v[7] & ~uns_q}}, byte_v};
      2'd1:    load_ext = {{16{half_v[15] & ~uns_q}}, half_v};
      default: load_ext = rdbuf_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = 32'd0;
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    unique case (state_q)
      StIdle: begin
        req_ready = ~rst;
        if (req_valid) begin
          accept = 1'b1;
          if (req_bad)                          state_d = StResp;
          else if (req_wr && req_size == 2'd2)  state_d = StWr;
          else                                  state_d = StRd;
        end
      end
      StRd: begin
        mem_enable = 1'b1;
        mem_addr   = base_q;
        state_d    = wr_q ? StWr : StResp;
      end
      StWr: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = base_q;
        mem_wdata  = merged;
        state_d    = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (wr_q || err_q) ? 32'd0 : load_ext;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed table-driven bench for lsu_mem_adapter with a behavioural word memory.
module tb_lsu_mem_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic        req_wr = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_enable, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  lsu_mem_adapter #(.MEM_BYTES(65536)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] tb_mem [0:16383];
  assign mem_rdata = tb_mem[mem_addr[15:2]];
  always @(posedge clk) if (mem_enable && mem_wr) tb_mem[mem_addr[15:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs [18];

  logic        rec_en [8];
  logic        rec_wr [8];
  logic [31:0] rec_addr [8];
  logic [31:0] rec_wd [8];
  int          lat_seen;
  logic        any_en;

  // Issues one request from IDLE and records per-cycle memory activity until rsp_valid.
  task automatic do_req(input vec_t v, input string name);
    @(negedge clk);
    req_valid = 1'b1; req_wr = v.wr; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    #1;
    chk({name, " ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat_seen = 0;
    any_en = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      rec_en[k] = mem_enable; rec_wr[k] = mem_wr; rec_addr[k] = mem_addr; rec_wd[k] = mem_wdata;
      any_en |= mem_enable;
      if (rsp_valid) begin
        lat_seen = k;
        break;
      end
    end
    chk({name, " latency"}, lat_seen, v.lat);
    chk({name, " err"}, {31'd0, rsp_err}, {31'd0, v.err});
    chk({name, " rdata"}, rsp_rdata, v.rdata);
    if (v.err) chk({name, " no mem access"}, {31'd0, any_en}, 32'd0);
    @(negedge clk);
    chk({name, " pulse ends"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) tb_mem[i] = 32'd0;

    //        wr    sz    uns   addr            wdata          err   rdata          lat
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0,         2};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF, 2};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'h1122_3344, 1'b0, 32'h0,         2};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0202, 32'h0000_00AA, 1'b0, 32'h0,         3};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0,         1'b0, 32'h11AA_3344, 2};
    vecs[5]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'h80F0_7F01, 1'b0, 32'h0,         2};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0302, 32'h0,         1'b0, 32'hFFFF_FFF0, 2};
    vecs[7]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0302, 32'h0,         1'b0, 32'h0000_00F0, 2};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0302, 32'h0,         1'b0, 32'hFFFF_80F0, 2};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0301, 32'h0,         1'b0, 32'h0000_007F, 2};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h0000_0101, 32'h0,         1'b1, 32'h0,         1};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,         1'b1, 32'h0,         1};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_FFFC, 32'h0,         1'b0, 32'h0,         2};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0,         1'b1, 32'h0,         1};
    vecs[14] = '{1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0,         1};
    vecs[15] = '{1'b1, 2'd1, 1'b0, 32'h0000_0302, 32'h0000_1234, 1'b0, 32'h0,         3};
    vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0,         1'b0, 32'h1234_7F01, 2};
    vecs[17] = '{1'b0, 2'd1, 1'b0, 32'h0000_0300, 32'h0,         1'b0, 32'h0000_7F01, 2};

    // Reset state
    #3;
    chk("reset req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset mem_enable", {31'd0, mem_enable}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("ready after reset", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      do_req(vecs[i], $sformatf("vec%0d", i));
      if (i == 3) begin
        chk("rmw rd enable", {30'd0, rec_en[1], rec_wr[1]}, 32'd2);
        chk("rmw rd addr", rec_addr[1], 32'h0000_0200);
        chk("rmw wr enable", {30'd0, rec_en[2], rec_wr[2]}, 32'd3);
        chk("rmw wr data", rec_wd[2], 32'h11AA_3344);
      end
    end

    // Reset during WR of a half store: nothing committed, no response.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h0000_0400; req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort in WR", {31'd0, mem_wr}, 32'd1);
    rst = 1'b1;
    #1 chk("abort mem_wr drops", {31'd0, mem_wr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort ready after reset", {31'd0, req_ready}, 32'd1);
    chk("abort mem untouched", tb_mem[32'h400 >> 2], 32'd0);
    begin
      logic saw_rsp = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        saw_rsp |= rsp_valid;
      end
      chk("abort no response", {31'd0, saw_rsp}, 32'd0);
    end
    do_req('{1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 1'b0, 32'h0, 2}, "abort readback");

    // Back-to-back loads with req_valid held high.
    begin
      logic [31:0] b_addr [3];
      logic [1:0]  b_size [3];
      logic        b_uns  [3];
      logic [31:0] b_exp  [3];
      int acc [3];
      int ni = 0, nr = 0, viol = 0;
      logic prev_rsp = 1'b0;
      b_addr[0] = 32'h100; b_size[0] = 2'd2; b_uns[0] = 1'b0; b_exp[0] = 32'hDEAD_BEEF;
      b_addr[1] = 32'h200; b_size[1] = 2'd2; b_uns[1] = 1'b0; b_exp[1] = 32'h11AA_3344;
      b_addr[2] = 32'h303; b_size[2] = 2'd0; b_uns[2] = 1'b1; b_exp[2] = 32'h0000_0012;
      for (int k = 0; k < 3; k++) acc[k] = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (ni < 3) begin
          req_valid = 1'b1; req_wr = 1'b0; req_size = b_size[ni];
          req_unsigned = b_uns[ni]; req_addr = b_addr[ni];
        end else begin
          req_valid = 1'b0;
        end
        #1;
        if (rsp_valid && (prev_rsp || req_ready)) viol++;
        if (rsp_valid && nr < 3) begin
          chk($sformatf("b2b rdata%0d", nr), rsp_rdata, b_exp[nr]);
          nr++;
        end
        prev_rsp = rsp_valid;
        if (req_ready && ni < 3) begin
          acc[ni] = cyc;
          ni++;
        end
      end
      chk("b2b accepts", ni, 3);
      chk("b2b responses", nr, 3);
      chk("b2b spacing 0-1", acc[1] - acc[0], 3);
      chk("b2b spacing 1-2", acc[2] - acc[1], 3);
      chk("b2b rsp violations", viol, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
